uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// FIFO-buffered 8N1 UART transmitter with registered, idle-high serial output.
// An accepted write reaches the line one edge after it lands; writes into a full FIFO are dropped and flagged.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          csr_uart_tx_valid,
  input  logic [7:0]                    csr_uart_tx_data,
  output logic                          uart_tx_full,
  output logic                          uart_tx_empty,
  output logic                          uart_tx_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   uart_tx_count,
  output logic                          uart_txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q;

  logic          push, pop, baud_wrap, have_data;
  logic [2:0]    bit_nxt;

  assign uart_tx_full  = (count_q == CW'(FIFO_DEPTH));
  assign uart_tx_empty = (count_q == '0) && (state_q == IDLE);
  assign uart_tx_ovf   = ovf_q;
  assign uart_tx_count = count_q;
  assign uart_txd      = txd_q;

  // Full is judged on registered count, so a same-edge pop never rescues a write.
  assign push      = csr_uart_tx_valid & ~uart_tx_full;
  assign have_data = (count_q != '0);
  assign baud_wrap = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign bit_nxt   = bit_q + 3'd1;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          baud_d  = '0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_nxt;
            txd_d = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (have_data) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= csr_uart_tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= csr_uart_tx_valid & uart_tx_full;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; a line monitor checks every frame against a byte scoreboard.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full, empty, ovf, txd;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  int         frames_seen = 0;
  bit         mon_busy = 1'b0;
  int         mon_k = 0;
  int         mon_bad = 0;
  int         mon_pos = 0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_exp = 1'b1;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .csr_uart_tx_valid(valid),
    .csr_uart_tx_data(data),
    .uart_tx_full(full),
    .uart_tx_empty(empty),
    .uart_tx_ovf(ovf),
    .uart_tx_count(count),
    .uart_txd(txd)
  );

  always #5 clk = ~clk;

  // Frame monitor: every cycle of a frame must match start/data/stop for the next scoreboard byte.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else begin
      if (!mon_busy && txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_k    = 0;
        mon_bad  = 0;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL frame_unexpected: line went low with nothing queued, got start bit, required idle");
          mon_byte = 8'h00;
        end else begin
          mon_byte = sb_q.pop_front();
        end
      end
      if (mon_busy) begin
        mon_pos = mon_k / CPB;
        if (mon_pos == 0)      mon_exp = 1'b0;
        else if (mon_pos == 9) mon_exp = 1'b1;
        else                   mon_exp = mon_byte[mon_pos-1];
        if (txd !== mon_exp) mon_bad++;
        mon_k++;
        if (mon_k == 10 * CPB) begin
          n_cmp++;
          if (mon_bad != 0) begin
            n_err++;
            $display("FAIL frame_bits byte=%02h: %0d wrong line cycles, required 0", mon_byte, mon_bad);
          end
          frames_seen++;
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic test_reset;
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (txd !== 1'b1)   begin n_err++; $display("FAIL reset_txd got %b required 1", txd); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d required 0", count); end
    n_cmp++; if (full !== 1'b0)  begin n_err++; $display("FAIL reset_full got %b required 0", full); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b required 1", empty); end
    n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b required 0", ovf); end
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_no_write got count %0d required 0", count); end
  endtask

  task automatic test_single;
    int n;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'hA5;
    sb_q.push_back(8'hA5);
    @(posedge clk); #1;
    valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d required 1", count); end
    n_cmp++; if (txd !== 1'b1)   begin n_err++; $display("FAIL single_txd_write_edge got %b required 1", txd); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty got %b required 0", empty); end
    @(posedge clk); #1;
    n_cmp++; if (txd !== 1'b0)   begin n_err++; $display("FAIL single_fall got %b required 0", txd); end
    n = 1;
    while (!empty && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (n != 41) begin n_err++; $display("FAIL single_empty_return edge %0d required 41", n); end
  endtask

  task automatic test_burst;
    logic [2:0] cnt_seen [6];
    logic       full_seen[6];
    logic       ovf_seen [6];
    logic [2:0] cnt_exp  [6];
    int n;
    int f0;
    cnt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    f0 = frames_seen;
    @(negedge clk);
    valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = 8'(i + 1);
      if (i < 5) sb_q.push_back(8'(i + 1));
      @(posedge clk); #1;
      cnt_seen[i]  = count;
      full_seen[i] = full;
      ovf_seen[i]  = ovf;
    end
    valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (cnt_seen[i] !== cnt_exp[i]) begin
        n_err++; $display("FAIL burst_count[%0d] got %0d required %0d", i, cnt_seen[i], cnt_exp[i]);
      end
    end
    n_cmp++; if (full_seen[3] !== 1'b0) begin n_err++; $display("FAIL burst_full_4th got %b required 0", full_seen[3]); end
    n_cmp++; if (full_seen[4] !== 1'b1) begin n_err++; $display("FAIL burst_full_5th got %b required 1", full_seen[4]); end
    n_cmp++; if (ovf_seen[4] !== 1'b0)  begin n_err++; $display("FAIL burst_ovf_5th got %b required 0", ovf_seen[4]); end
    n_cmp++; if (ovf_seen[5] !== 1'b1)  begin n_err++; $display("FAIL burst_ovf_6th got %b required 1", ovf_seen[5]); end
    @(posedge clk); #1;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL burst_ovf_one_cycle got %b required 0", ovf); end
    // First frame started at edge 2, so its stop bit ends and the next pop lands on edge 42.
    repeat (34) @(posedge clk);
    #1;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL burst_count_pre_pop got %0d required 4", count); end
    valid = 1'b1;
    data  = 8'h77;
    @(posedge clk); #1;
    valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL popfull_count got %0d required 3", count); end
    n_cmp++; if (ovf !== 1'b1)   begin n_err++; $display("FAIL popfull_ovf got %b required 1", ovf); end
    n = 42;
    while (!empty && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (n != 202) begin n_err++; $display("FAIL burst_continuous empty at edge %0d required 202", n); end
    n_cmp++; if (frames_seen - f0 != 5) begin n_err++; $display("FAIL burst_frames got %0d required 5", frames_seen - f0); end
  endtask

  task automatic test_rst_mid;
    int lows;
    int n;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'hFF;
    sb_q.push_back(8'hFF);
    @(posedge clk); #1;
    valid = 1'b0;
    // Start bit from edge 1, data bit 3 spans edges 17..20.
    repeat (18) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (txd !== 1'b1)   begin n_err++; $display("FAIL rstmid_txd got %b required 1", txd); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count got %0d required 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rstmid_empty got %b required 1", empty); end
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0) begin n_err++; $display("FAIL rstmid_no_low got %0d low cycles required 0", lows); end
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h3C;
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(8'h3C);
    @(posedge clk); #1;
    valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL rst_release_write got count %0d required 1", count); end
    n = 0;
    while (!empty && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_release_drain got empty %b required 1", empty); end
  endtask

  task automatic test_wrap;
    int maxc;
    int n;
    int f0;
    maxc = 0;
    f0 = frames_seen;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = 8'($urandom);
      sb_q.push_back(data);
      @(posedge clk); #1;
      valid = 1'b0;
      if (int'(count) > maxc) maxc = int'(count);
      repeat (39) begin
        @(posedge clk); #1;
        if (int'(count) > maxc) maxc = int'(count);
      end
    end
    n = 0;
    while (!empty && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (maxc != 1) begin n_err++; $display("FAIL wrap_max_count got %0d required 1", maxc); end
    n_cmp++; if (frames_seen - f0 != 12) begin n_err++; $display("FAIL wrap_frames got %0d required 12", frames_seen - f0); end
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL wrap_scoreboard got %0d left required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_rst_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
